// File: rtl/spi_periph_pkg.sv
// ---------------------------------------------------------------------------
// spi_periph_pkg : shared command codes, state encoding and sync depth
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package spi_periph_pkg;

  localparam logic [7:0]  CMD_WRITE  = 8'h0A;
  localparam logic [7:0]  CMD_READ   = 8'h0B;
  localparam int unsigned SYNC_DEPTH = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_ADDR    = 3'd2,
    ST_DATA_WR = 3'd3,
    ST_DATA_RD = 3'd4,
    ST_IGNORE  = 3'd5
  } state_e;

endpackage

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// ---------------------------------------------------------------------------
// spi_sync_edge : multi-flop synchroniser with single-cycle rise/fall pulses
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_sync_edge
  import spi_periph_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pin_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], pin_i};
      prev_q <= sync_q[SYNC_DEPTH-1];
    end
  end

  // Pulses are combinational so the consumer acts on the third clock edge.
  assign rise_o =  sync_q[SYNC_DEPTH-1] & ~prev_q;
  assign fall_o = ~sync_q[SYNC_DEPTH-1] &  prev_q;

endmodule

`default_nettype wire

// File: rtl/spi_peripheral.sv
// ---------------------------------------------------------------------------
// spi_peripheral : SPI mode-0 responder with byte register map and burst access
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_peripheral
  import spi_periph_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter logic [7:0]  DEVID  = 8'hAD
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_spi_sclk,
  input  logic              i_spi_csn,
  input  logic              i_spi_copi,
  output logic              o_spi_cipo,
  output logic              o_spi_cipo_oe,
  input  logic              i_reg_we,
  input  logic [ADDR_W-1:0] i_reg_addr,
  input  logic [7:0]        i_reg_wdata,
  output logic              o_wr_dv,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data,
  output logic              o_busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic sclk_rise, sclk_fall, csn_rise, csn_fall;
  logic [SYNC_DEPTH-1:0] copi_sync_q;
  logic copi_s;

  state_e            state_q, state_d;
  logic              mode_rd_q, mode_rd_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [6:0]        rx_q, rx_d;
  logic [7:0]        tx_q, tx_d;
  logic              byte_done_q, byte_done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_dv_q, wr_dv_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [7:0]        regs_q [DEPTH];
  logic [7:0]        byte_val;
  logic [7:0]        rd_byte;
  logic              spi_we;

  spi_sync_edge u_sync_sclk (
    .clk_i  (i_clk),
    .rst_ni (i_reset_n),
    .pin_i  (i_spi_sclk),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_sync_edge u_sync_csn (
    .clk_i  (i_clk),
    .rst_ni (i_reset_n),
    .pin_i  (i_spi_csn),
    .rise_o (csn_rise),
    .fall_o (csn_fall)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) copi_sync_q <= '0;
    else            copi_sync_q <= {copi_sync_q[SYNC_DEPTH-2:0], i_spi_copi};
  end
  assign copi_s = copi_sync_q[SYNC_DEPTH-1];

  assign byte_val = {rx_q, copi_s};
  assign rd_byte  = (addr_q == '0) ? DEVID : regs_q[addr_q];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_IDLE;
      mode_rd_q   <= 1'b0;
      bitcnt_q    <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      byte_done_q <= 1'b0;
      addr_q      <= '0;
      wr_dv_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      mode_rd_q   <= mode_rd_d;
      bitcnt_q    <= bitcnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      byte_done_q <= byte_done_d;
      addr_q      <= addr_d;
      wr_dv_q     <= wr_dv_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_rd_d   = mode_rd_q;
    bitcnt_d    = bitcnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    byte_done_d = byte_done_q;
    addr_d      = addr_q;
    wr_dv_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    spi_we      = 1'b0;

    if (state_q == ST_IDLE) begin
      if (csn_fall) begin
        state_d     = ST_CMD;
        bitcnt_d    = '0;
        byte_done_d = 1'b0;
      end
    end else if (csn_rise) begin
      // Any partial byte is simply dropped with the counter.
      state_d     = ST_IDLE;
      bitcnt_d    = '0;
      byte_done_d = 1'b0;
      tx_d        = '0;
    end else begin
      if (sclk_rise) begin
        rx_d     = byte_val[6:0];
        bitcnt_d = bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd7) begin
          byte_done_d = 1'b1;
          case (state_q)
            ST_CMD: begin
              if (byte_val == CMD_WRITE) begin
                state_d   = ST_ADDR;
                mode_rd_d = 1'b0;
              end else if (byte_val == CMD_READ) begin
                state_d   = ST_ADDR;
                mode_rd_d = 1'b1;
              end else begin
                state_d   = ST_IGNORE;
              end
            end
            ST_ADDR: begin
              addr_d  = byte_val[ADDR_W-1:0];
              state_d = mode_rd_q ? ST_DATA_RD : ST_DATA_WR;
            end
            ST_DATA_WR: begin
              if (addr_q != '0) begin
                spi_we    = 1'b1;
                wr_dv_d   = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = byte_val;
              end
              addr_d = addr_q + ADDR_W'(1);
            end
            default: ;
          endcase
        end
      end
      // Snapshot the outgoing byte on the fall after a completed byte.
      if (sclk_fall && state_q == ST_DATA_RD) begin
        if (byte_done_q) begin
          tx_d        = rd_byte;
          byte_done_d = 1'b0;
          addr_d      = addr_q + ADDR_W'(1);
        end else begin
          tx_d = {tx_q[6:0], 1'b0};
        end
      end
    end
  end

  // The SPI write is placed last so it overrides a same-cycle local write.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      if (i_reg_we && i_reg_addr != '0) regs_q[i_reg_addr] <= i_reg_wdata;
      if (spi_we) regs_q[addr_q] <= byte_val;
    end
  end

  assign o_spi_cipo    = (state_q == ST_DATA_RD) & tx_q[7];
  assign o_spi_cipo_oe = (state_q == ST_DATA_RD);
  assign o_wr_dv       = wr_dv_q;
  assign o_wr_addr     = wr_addr_q;
  assign o_wr_data     = wr_data_q;
  assign o_busy        = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: doc/spi_peripheral.md
Name: spi_peripheral

Overview:
SPI mode-0 responder that models the accelerometer end of the SPI link.
- Decodes a write/read command byte, an address byte, then a burst of data bytes against an internal byte-wide register map, with auto-increment on the address.
- Lets the on-chip SPI controller and processor firmware be exercised in simulation without the real sensor.
- Exposes a local write port so the bench or system can update sample registers, and a strobe for every byte written over SPI.

Parameters:
ADDR_W, 6, register map address width; the map holds 2^ADDR_W bytes.
DEVID, 8'hAD, fixed read-only value at address 0.

Ports:
i_clk  input  1  system clock; all logic runs on this clock.
i_reset_n  input  1  asynchronous active-low reset.
i_spi_sclk  input  1  SPI clock from the controller; asynchronous to i_clk.
i_spi_csn  input  1  chip select, active low; asynchronous.
i_spi_copi  input  1  controller-out data; asynchronous.
o_spi_cipo  output  1  peripheral-out data.
o_spi_cipo_oe  output  1  high while CSN is low and the block is in the DATA_RD state.
i_reg_we  input  1  local register write strobe.
i_reg_addr  input  ADDR_W  local write address.
i_reg_wdata  input  8  local write data.
o_wr_dv  output  1  one-cycle pulse: a byte was written over SPI.
o_wr_addr  output  ADDR_W  address of that write; held until the next pulse.
o_wr_data  output  8  data of that write; held until the next pulse.
o_busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset values: all outputs 0; all registers 0; state IDLE; bit counter 0. Address 0 always reads DEVID.
- Synchronisation and timing:
  - sclk, csn and copi each pass through a 2-FF synchroniser; sclk and csn then get edge detection.
  - Pin edge to internal event latency is 3 i_clk cycles.
  - Required: SCLK high and low times are each at least 4 i_clk cycles, so SCLK ≤ i_clk/8.
- Bit sampling:
  - Sample copi on each synchronised SCLK rising edge, MSB first, into an 8-bit rx shift register.
  - A 3-bit counter counts bits; the 8th rise completes a byte and sets byte_done.
- States: IDLE, CMD, ADDR, DATA_WR, DATA_RD, IGNORE.
  - IDLE → CMD on csn falling edge; clear the counter.
  - CMD, on byte complete:
    - 8'h0A → ADDR with mode=write.
    - 8'h0B → ADDR with mode=read.
    - Any other value → IGNORE.
  - ADDR, on byte complete: load the address pointer with the low ADDR_W bits; go to DATA_WR or DATA_RD according to mode.
  - DATA_WR, each completed byte:
    - If addr ≠ 0: write the byte to reg[addr] and pulse o_wr_dv with o_wr_addr/o_wr_data, within 4 cycles after the synchronised rise.
    - If addr = 0: no write and no pulse.
    - In both cases: addr = addr+1 modulo 2^ADDR_W.
  - DATA_RD, CIPO timing:
    - On each synchronised SCLK falling edge: if byte_done is set, load the tx shift register with reg[addr] (or DEVID at address 0), clear byte_done and increment addr; otherwise shift left.
    - o_spi_cipo = tx[7].
    - The byte is snapshotted at load time, so later writes do not affect the byte in flight.
  - IGNORE: o_spi_cipo = 0 and no writes until CSN rises.
  - Any state other than IDLE → IDLE on csn rising edge.
- Boundary conditions:
  - CSN rising edge mid-byte: discard the partial byte, with no write and no o_wr_dv; counter to 0; o_spi_cipo = 0 and oe = 0 within 4 cycles.
  - Address wrap: 2^ADDR_W−1 → 0, for both burst reads and burst writes.
  - Local write and SPI write to the same address in the same cycle: the SPI write wins. A local write to address 0 is ignored.
  - Outside DATA_RD: o_spi_cipo = 0.
  - Async reset mid-transaction: immediately return to IDLE with all outputs 0. A CSN that is still low after reset release is ignored until it goes high and then low again.

Decomposition:
- Package spi_periph_pkg holds:
  - CMD_WRITE = 8'h0A and CMD_READ = 8'h0B;
  - the state enum typedef;
  - the sync depth constant (2).
- Sub-module spi_sync_edge: a 2-FF synchroniser with rise/fall pulse outputs, instantiated for sclk and csn. copi uses only the synchroniser part.

Test Plan:
- Read DEVID: CSN low; send 0x0B, 0x00, then 8 dummy clocks at i_clk/8 → CIPO returns 0xAD; o_wr_dv never pulses.
- Single write: send 0x0A, 0x20, 0x5A → exactly one o_wr_dv pulse with o_wr_addr=0x20 and o_wr_data=0x5A. A follow-up read 0x0B, 0x20 → 0x5A.
- Burst wrap:
  - Local writes reg[0x3E]=0x11 and reg[0x3F]=0x22.
  - Read 0x0B, 0x3E with three data bytes → 0x11, 0x22, 0xAD.
  - Write 0x0A, 0x3F with 0x33, 0x44 → one o_wr_dv (addr 0x3F, data 0x33); the byte at address 0 is dropped.
- Abort: send 0x0A, 0x10, then 4 bits of 0xFF, then CSN high → no o_wr_dv and reg[0x10] stays 0. The next full read of 0x10 returns 0x00.
- Unknown command: send 0x55 followed by 16 clocks → CIPO stays 0, oe stays 0, no writes; o_busy drops within 4 cycles after CSN rises.
- Reset mid-read: assert i_reset_n low during the DATA_RD byte → all outputs 0 immediately. After release with CSN still low, further SCLK is ignored until CSN is toggled high and low.
